// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: decodes RV32I load/store funct3, drives the dmem port
// with lane-replicated data and byte enables, stalls until dmem_resp, and aligns/extends loads.
module lsu_mem_stage #(
  parameter int RESP_TIMEOUT = 0,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);

  logic [1:0]       r_state;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic             r_is_load;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_mbe;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [31:0]      r_load_data;

  logic        w_accept;
  logic        w_f3_ok;
  logic        w_aligned;
  logic        w_legal;
  logic        w_timeout;
  logic [3:0]  w_st_mbe;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;

  assign w_accept  = (r_state == S_IDLE) && req_valid && (is_load || is_store);
  assign w_legal   = w_f3_ok && w_aligned;
  assign w_timeout = (RESP_TIMEOUT != 0) && (r_cnt == TO_LAST);

  // funct3[1:0] encodes access size for every legal opcode; funct3[2] is the unsigned flag.
  always_comb begin
    w_f3_ok = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
        default:                                w_f3_ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
        default:                w_f3_ok = 1'b0;
      endcase
    end
    case (funct3[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~addr[0];
      2'b10:   w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        w_st_mbe   = 4'b0001 << addr[1:0];
        w_st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_st_mbe   = 4'b0011 << addr[1:0];
        w_st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_st_mbe   = 4'b1111;
        w_st_wdata = store_data;
      end
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata[{r_off, 3'b000} +: 8];
    w_half = dmem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {24'b0, w_byte};
      3'b101:  w_ld_data = {16'b0, w_half};
      default: w_ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_funct3    <= '0;
      r_off       <= '0;
      r_is_load   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mbe       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3  <= funct3;
            r_off     <= addr[1:0];
            r_is_load <= is_load;
            r_addr    <= {addr[31:2], 2'b00};
            r_wdata   <= is_load ? 32'b0 : w_st_wdata;
            r_mbe     <= is_load ? 4'b0 : w_st_mbe;
            r_cnt     <= '0;
            if (w_legal) begin
              r_state <= S_ACCESS;
            end else begin
              r_state     <= S_DONE;
              r_err       <= 1'b1;
              r_load_data <= '0;
            end
          end
        end
        S_ACCESS: begin
          // A response in the final allowed cycle still wins over the timeout.
          if (dmem_resp) begin
            r_state     <= S_DONE;
            r_err       <= 1'b0;
            r_load_data <= r_is_load ? w_ld_data : 32'b0;
          end else if (w_timeout) begin
            r_state     <= S_DONE;
            r_err       <= 1'b1;
            r_load_data <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall        = w_accept || (r_state == S_ACCESS);
  assign done         = (r_state == S_DONE);
  assign err          = r_err;
  assign load_data    = r_load_data;
  assign dmem_read    = (r_state == S_ACCESS) && r_is_load;
  assign dmem_write   = (r_state == S_ACCESS) && !r_is_load;
  assign dmem_address = r_addr;
  assign dmem_wdata   = r_wdata;
  assign dmem_mbe     = r_mbe;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized bench for lsu_mem_stage against an arithmetic reference model of
// RV32I load/store legality, lane placement, extension and response timing.
module tb_lsu_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, err, dmem_read, dmem_write;
  logic [31:0] load_data, dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_stage #(.RESP_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall), .done(done),
    .load_data(load_data), .err(err), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: size in bytes, legality, lane placement and extension by plain arithmetic.
  function automatic void model(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd,
                                output bit legal, output logic [3:0] mbe,
                                output logic [31:0] wd, output logic [31:0] ldv);
    int size, off;
    longint v;
    off   = int'(a % 4);
    size  = 1 << f3[1:0];
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    if (legal && (a % size) != 0) legal = 0;
    mbe = '0;
    wd  = '0;
    ldv = '0;
    if (legal && !ld) begin
      mbe = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % size) +: 8];
    end
    if (legal && ld) begin
      v = (longint'(rd) >> (8 * off)) % (longint'(1) << (8 * size));
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      ldv = 32'(v);
    end
  endfunction

  // One access; lat = ACCESS cycle (1-based) in which dmem_resp is driven, > TO means never.
  task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int lat,
                        output logic [31:0] got_ld);
    bit          legal, hold, got_done;
    logic [3:0]  e_mbe;
    logic [31:0] e_wd, e_ld;
    int          acc, done_cyc, e_acc, e_done;
    logic        e_err;
    model(ld, f3, a, sd, rd, legal, e_mbe, e_wd, e_ld);
    e_err  = !legal || (lat > TO);
    e_acc  = !legal ? 0 : ((lat > TO) ? TO : lat);
    e_done = e_acc + 1;
    if (e_err) e_ld = '0;
    @(negedge clk);
    req_valid = 1'b1; is_load = ld; is_store = !ld; funct3 = f3; addr = a; store_data = sd;
    dmem_resp = 1'b0; dmem_rdata = $urandom;
    #1;
    check("stall_accept", stall, 1);
    @(negedge clk);
    hold = bit'($urandom_range(0, 1));
    req_valid = hold; addr = $urandom; store_data = $urandom; funct3 = 3'($urandom_range(0, 7));
    acc = 0; done_cyc = 0; got_done = 0; got_ld = 'x;
    for (int c = 1; c <= 12 && !got_done; c++) begin
      if (done) begin
        got_done = 1; done_cyc = c; got_ld = load_data;
        check("done_err", err, e_err);
        check("done_ld", load_data, e_ld);
        check("done_stall", stall, 0);
        check("done_noreq", dmem_read | dmem_write, 0);
      end else begin
        check("busy_stall", stall, 1);
        if (dmem_read || dmem_write) begin
          acc++;
          check("rd_type", dmem_read, ld);
          check("address", dmem_address, {a[31:2], 2'b00});
          check("mbe", dmem_mbe, e_mbe);
          if (!ld) check("wdata", dmem_wdata, e_wd);
        end
        dmem_resp  = (dmem_read || dmem_write) && (acc == lat);
        dmem_rdata = dmem_resp ? rd : $urandom;
        @(negedge clk);
        dmem_resp = 1'b0;
      end
    end
    check("done_cycle", done_cyc, e_done);
    check("access_cycles", acc, e_acc);
    req_valid = 1'b0;
    dmem_resp = bit'($urandom_range(0, 1));
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ld_hold", load_data, e_ld);
    dmem_resp = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    rst = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; store_data = '0; dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ld", load_data, 0);
    check("rst_req", {dmem_read, dmem_write}, 0);
    check("rst_addr", dmem_address, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_mbe", dmem_mbe, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, r); check("plan_lw", r, 32'hDEADBEEF);
    run_op(1, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, r); check("plan_lb", r, 32'hFFFFFF80);
    run_op(1, 3'b100, 32'h103, 32'h0, 32'h80112233, 2, r); check("plan_lbu", r, 32'h00000080);
    run_op(1, 3'b001, 32'h102, 32'h0, 32'h80112233, 1, r); check("plan_lh", r, 32'hFFFF8011);
    run_op(0, 3'b000, 32'h201, 32'hA5, 32'h0, 1, r);
    run_op(0, 3'b001, 32'h202, 32'h1234, 32'h0, 2, r);
    run_op(1, 3'b010, 32'h102, 32'h0, 32'h12345678, 1, r); check("plan_lw_mis", r, 0);
    run_op(1, 3'b011, 32'h100, 32'h0, 32'h12345678, 1, r); check("plan_f3_bad", r, 0);
    run_op(1, 3'b010, 32'h300, 32'h0, 32'h55AA55AA, 99, r); check("plan_timeout", r, 0);
    run_op(1, 3'b010, 32'h300, 32'h0, 32'h55AA55AA, 4, r); check("plan_after_to", r, 32'h55AA55AA);

    // Reset landing in the second ACCESS cycle discards the access.
    @(negedge clk);
    req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h400;
    repeat (2) @(negedge clk);
    check("pre_rst_read", dmem_read, 1);
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_read", dmem_read, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_done", done, 0);
    dmem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_resp_done", done, 0);
      check("stray_resp_req", dmem_read | dmem_write, 0);
    end
    dmem_resp = 1'b0;

    for (int n = 0; n < 250; n++) begin
      logic        ld;
      logic [31:0] a;
      ld = 1'($urandom_range(0, 1));
      a  = $urandom;
      run_op(ld, 3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom_range(1, 6), r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
